// File: rtl/apb_slave_decoder.sv
// APB slave that fans one APB port out to NUM_CH one-hot channel enables; optional APB_TIMEOUT_EN bounds wait states.
// Latency: SETUP + one ACCESS cycle minimum, plus one cycle per low cycle of the selected i_Ch_Ready.
// Backpressure: o_Pready follows the selected channel's ready combinationally; unmapped addresses complete at once with o_Pslverr.
module apb_slave_decoder #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CH     = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                         i_Pclk,
    input  logic                         i_Presetn,
    input  logic                         i_Psel,
    input  logic                         i_Penable,
    input  logic                         i_Pwrite,
    input  logic [ADDR_WIDTH-1:0]        i_Paddr,
    input  logic [DATA_WIDTH-1:0]        i_Pwdata,
    output logic [DATA_WIDTH-1:0]        o_Prdata,
    output logic                         o_Pready,
    output logic                         o_Pslverr,
    output logic [NUM_CH-1:0]            o_Enable,
    output logic                         o_Write,
    output logic [DATA_WIDTH-1:0]        o_Wdata,
    input  logic [NUM_CH-1:0]            i_Ch_Ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] i_Ch_Rdata
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

    localparam logic [ADDR_WIDTH:0] LP_NUM_CH = (ADDR_WIDTH+1)'(NUM_CH);

    if (NUM_CH < 1 || NUM_CH > (1 << ADDR_WIDTH) || TIMEOUT < 1) begin : g_bad_params
        $error("apb_slave_decoder: illegal parameter combination");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NUM_CH-1:0]     w_sel;
    logic                  w_ch_rdy;
    logic [DATA_WIDTH-1:0] w_ch_rdata;
    logic                  w_addr_ok;
    logic                  w_access;
    logic                  w_timeout;
    logic                  w_pready;
    logic                  w_latch;

    assign w_addr_ok = {1'b0, r_addr} < LP_NUM_CH;
    assign w_access  = (r_state == ST_ACCESS);

    always_comb begin
        w_sel      = '0;
        w_ch_rdy   = 1'b0;
        w_ch_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (r_addr == ADDR_WIDTH'(k)) begin
                w_sel[k]   = 1'b1;
                w_ch_rdy   = i_Ch_Ready[k];
                w_ch_rdata = i_Ch_Rdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int LP_CW = $clog2(TIMEOUT + 1);
    logic [LP_CW-1:0] r_cnt;

    // SETUP always precedes ACCESS, so clearing there covers every entry into ACCESS.
    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            r_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_cnt <= '0;
        end else if (w_access && w_addr_ok && !w_ch_rdy && !w_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = w_access && w_addr_ok && !w_ch_rdy && (r_cnt == LP_CW'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_pready  = w_access && (!w_addr_ok || w_ch_rdy || w_timeout);
    assign o_Pready  = w_pready;
    assign o_Pslverr = w_access && (!w_addr_ok || w_timeout);
    assign o_Enable  = w_access ? w_sel : '0;
    assign o_Prdata  = (w_pready && !r_write && w_addr_ok) ? w_ch_rdata : '0;
    assign o_Write   = r_write;
    assign o_Wdata   = r_wdata;

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Psel && !i_Penable) begin
                    w_state_nxt = ST_SETUP;
                    w_latch     = 1'b1;
                end
            end
            ST_SETUP: begin
                w_state_nxt = (i_Psel && i_Penable) ? ST_ACCESS : ST_IDLE;
            end
            ST_ACCESS: begin
                // Completion wins over an abort seen in the same cycle.
                if (w_pready) begin
                    if (i_Psel && !i_Penable) begin
                        w_state_nxt = ST_SETUP;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (!i_Psel || !i_Penable) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_addr  <= i_Paddr;
                r_write <= i_Pwrite;
                r_wdata <= i_Pwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_decoder.sv
// Self-checking bench for apb_slave_decoder (default parameters, NUM_CH=4, DATA_WIDTH=8).
// Expected transfer results are queued before each transfer and popped when the DUT completes or times out.
module tb_apb_slave_decoder;

    logic        clk;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [3:0]  paddr;
    logic [7:0]  pwdata;
    logic [7:0]  o_prdata;
    logic        o_pready, o_pslverr, o_write;
    logic [3:0]  o_enable;
    logic [7:0]  o_wdata;
    logic [3:0]  ch_ready;
    logic [31:0] ch_rdata;

    typedef struct {
        logic [7:0] rd;
        logic        err;
        int          acc;
        logic [3:0]  en;
        logic        done;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int         vectors;
    int         miscompares;
    int         acc;
    logic [3:0] en1, enp;
    logic       enst, done, err, wro;
    logic [7:0] rd, rdw, wdo;

    apb_slave_decoder dut (
        .i_Pclk     (clk),
        .i_Presetn  (rst_n),
        .i_Psel     (psel),
        .i_Penable  (penable),
        .i_Pwrite   (pwrite),
        .i_Paddr    (paddr),
        .i_Pwdata   (pwdata),
        .o_Prdata   (o_prdata),
        .o_Pready   (o_pready),
        .o_Pslverr  (o_pslverr),
        .o_Enable   (o_enable),
        .o_Write    (o_write),
        .o_Wdata    (o_wdata),
        .i_Ch_Ready (ch_ready),
        .i_Ch_Rdata (ch_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired: got running, expected finished");
        $fatal(1);
    end

    // One transfer from IDLE; ACCESS cycle n holds the selected channel not-ready while n <= stall.
    task automatic do_xfer(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                           input int stall, input int bound,
                           output int n, output logic [3:0] en_first, output logic en_stable,
                           output logic [7:0] rdata, output logic serr, output logic [7:0] rd_wait,
                           output logic fin, output logic [3:0] en_post,
                           output logic [7:0] wd_obs, output logic wr_obs);
        n = 0; en_first = '0; en_stable = 1'b1; rdata = '0; serr = 1'b0;
        rd_wait = '0; fin = 1'b0; wd_obs = '0; wr_obs = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; ch_ready = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk);
        while (!fin && n < bound) begin
            #1;
            n++;
            ch_ready = (n <= stall) ? ~(4'b0001 << addr) : 4'hF;
            #1;
            if (n == 1) begin
                en_first = o_enable;
                wd_obs   = o_wdata;
                wr_obs   = o_write;
            end else if (o_enable !== en_first) begin
                en_stable = 1'b0;
            end
            if (o_pready) begin
                fin   = 1'b1;
                rdata = o_prdata;
                serr  = o_pslverr;
            end else begin
                rd_wait = rd_wait | o_prdata;
            end
            @(posedge clk);
        end
        #1;
        psel = 1'b0; penable = 1'b0; ch_ready = 4'hF;
        if (!fin) @(posedge clk);
        #1;
        en_post = o_enable;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        ch_ready = 4'hF;
        ch_rdata = {8'hD3, 8'h77, 8'h3C, 8'h5A};
        #12;
        vectors++; if (o_enable !== 4'h0) begin miscompares++; $display("FAIL rst_enable got %b exp 0000", o_enable); end
        vectors++; if (o_pready !== 1'b0) begin miscompares++; $display("FAIL rst_pready got %b exp 0", o_pready); end
        vectors++; if (o_pslverr !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr got %b exp 0", o_pslverr); end
        vectors++; if (o_prdata !== 8'h00) begin miscompares++; $display("FAIL rst_prdata got %h exp 00", o_prdata); end
        vectors++; if (o_write !== 1'b0) begin miscompares++; $display("FAIL rst_write got %b exp 0", o_write); end
        vectors++; if (o_wdata !== 8'h00) begin miscompares++; $display("FAIL rst_wdata got %h exp 00", o_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write;
        sb.push_back('{8'h00, 1'b0, 1, 4'b0100, 1'b1});
        do_xfer(1'b1, 4'd2, 8'hA5, 0, 20, acc, en1, enst, rd, err, rdw, done, enp, wdo, wro);
        e = sb.pop_front();
        vectors++; if (done !== e.done) begin miscompares++; $display("FAIL wr_done got %b exp %b", done, e.done); end
        vectors++; if (acc !== e.acc) begin miscompares++; $display("FAIL wr_cycles got %0d exp %0d", acc, e.acc); end
        vectors++; if (en1 !== e.en) begin miscompares++; $display("FAIL wr_enable got %b exp %b", en1, e.en); end
        vectors++; if (err !== e.err) begin miscompares++; $display("FAIL wr_pslverr got %b exp %b", err, e.err); end
        vectors++; if (rd !== e.rd) begin miscompares++; $display("FAIL wr_prdata got %h exp %h", rd, e.rd); end
        vectors++; if (wdo !== 8'hA5) begin miscompares++; $display("FAIL wr_wdata got %h exp a5", wdo); end
        vectors++; if (wro !== 1'b1) begin miscompares++; $display("FAIL wr_write got %b exp 1", wro); end
        vectors++; if (enp !== 4'h0) begin miscompares++; $display("FAIL wr_enable_after got %b exp 0000", enp); end
    endtask

    task automatic test_read_wait;
        sb.push_back('{8'h3C, 1'b0, 6, 4'b0010, 1'b1});
        do_xfer(1'b0, 4'd1, 8'h00, 5, 20, acc, en1, enst, rd, err, rdw, done, enp, wdo, wro);
        e = sb.pop_front();
        vectors++; if (done !== e.done) begin miscompares++; $display("FAIL rdw_done got %b exp %b", done, e.done); end
        vectors++; if (acc !== e.acc) begin miscompares++; $display("FAIL rdw_cycles got %0d exp %0d", acc, e.acc); end
        vectors++; if (en1 !== e.en) begin miscompares++; $display("FAIL rdw_enable got %b exp %b", en1, e.en); end
        vectors++; if (enst !== 1'b1) begin miscompares++; $display("FAIL rdw_enable_stable got %b exp 1", enst); end
        vectors++; if (rd !== e.rd) begin miscompares++; $display("FAIL rdw_prdata got %h exp %h", rd, e.rd); end
        vectors++; if (rdw !== 8'h00) begin miscompares++; $display("FAIL rdw_prdata_waiting got %h exp 00", rdw); end
        vectors++; if (err !== e.err) begin miscompares++; $display("FAIL rdw_pslverr got %b exp %b", err, e.err); end
        vectors++; if (enp !== 4'h0) begin miscompares++; $display("FAIL rdw_enable_after got %b exp 0000", enp); end
    endtask

    task automatic test_invalid;
        logic [3:0] addrs [2];
        addrs[0] = 4'd7;
        addrs[1] = 4'd4;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{8'h00, 1'b1, 1, 4'b0000, 1'b1});
            do_xfer(1'b0, addrs[i], 8'h00, 0, 20, acc, en1, enst, rd, err, rdw, done, enp, wdo, wro);
            e = sb.pop_front();
            vectors++; if (done !== e.done) begin miscompares++; $display("FAIL inv%0d_done got %b exp %b", addrs[i], done, e.done); end
            vectors++; if (acc !== e.acc) begin miscompares++; $display("FAIL inv%0d_cycles got %0d exp %0d", addrs[i], acc, e.acc); end
            vectors++; if (en1 !== e.en) begin miscompares++; $display("FAIL inv%0d_enable got %b exp %b", addrs[i], en1, e.en); end
            vectors++; if (err !== e.err) begin miscompares++; $display("FAIL inv%0d_pslverr got %b exp %b", addrs[i], err, e.err); end
            vectors++; if (rd !== e.rd) begin miscompares++; $display("FAIL inv%0d_prdata got %h exp %h", addrs[i], rd, e.rd); end
        end
    endtask

    task automatic test_setup_abort;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd1; pwdata = 8'h6E;
        @(posedge clk); #1;
        psel = 1'b0;
        #1;
        vectors++; if (o_enable !== 4'h0) begin miscompares++; $display("FAIL abort_setup_enable got %b exp 0000", o_enable); end
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            vectors++; if (o_enable !== 4'h0 || o_pready !== 1'b0) begin
                miscompares++; $display("FAIL abort_idle%0d got en=%b rdy=%b exp en=0000 rdy=0", c, o_enable, o_pready);
            end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_back_to_back;
        sb.push_back('{8'h00, 1'b0, 1, 4'b0001, 1'b1});
        sb.push_back('{8'hD3, 1'b0, 1, 4'b1000, 1'b1});
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 8'h11; ch_ready = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        penable = 1'b0; pwrite = 1'b0; paddr = 4'd3; pwdata = 8'h22;
        #1;
        e = sb.pop_front();
        vectors++; if (o_enable !== e.en) begin miscompares++; $display("FAIL b2b_first_enable got %b exp %b", o_enable, e.en); end
        vectors++; if (o_pready !== e.done || o_pslverr !== e.err) begin
            miscompares++; $display("FAIL b2b_first_resp got rdy=%b err=%b exp rdy=%b err=%b", o_pready, o_pslverr, e.done, e.err);
        end
        vectors++; if (o_wdata !== 8'h11) begin miscompares++; $display("FAIL b2b_first_wdata got %h exp 11", o_wdata); end
        @(posedge clk); #1;
        penable = 1'b1;
        #1;
        vectors++; if (o_enable !== 4'h0) begin miscompares++; $display("FAIL b2b_setup_enable got %b exp 0000", o_enable); end
        vectors++; if (o_write !== 1'b0) begin miscompares++; $display("FAIL b2b_setup_write got %b exp 0", o_write); end
        @(posedge clk); #2;
        e = sb.pop_front();
        vectors++; if (o_enable !== e.en) begin miscompares++; $display("FAIL b2b_second_enable got %b exp %b", o_enable, e.en); end
        vectors++; if (o_pready !== e.done) begin miscompares++; $display("FAIL b2b_second_pready got %b exp %b", o_pready, e.done); end
        vectors++; if (o_prdata !== e.rd) begin miscompares++; $display("FAIL b2b_second_prdata got %h exp %h", o_prdata, e.rd); end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_stall;
        int bound;
`ifdef APB_TIMEOUT_EN
        sb.push_back('{8'h5A, 1'b1, 16, 4'b0001, 1'b1});
        bound = 40;
`else
        sb.push_back('{8'h00, 1'b0, 100, 4'b0001, 1'b0});
        bound = 100;
`endif
        do_xfer(1'b0, 4'd0, 8'h00, 1000, bound, acc, en1, enst, rd, err, rdw, done, enp, wdo, wro);
        e = sb.pop_front();
        vectors++; if (done !== e.done) begin miscompares++; $display("FAIL stall_done got %b exp %b", done, e.done); end
        vectors++; if (acc !== e.acc) begin miscompares++; $display("FAIL stall_cycles got %0d exp %0d", acc, e.acc); end
        vectors++; if (en1 !== e.en || enst !== 1'b1) begin
            miscompares++; $display("FAIL stall_enable got %b stable=%b exp %b stable=1", en1, enst, e.en);
        end
        vectors++; if (err !== e.err) begin miscompares++; $display("FAIL stall_pslverr got %b exp %b", err, e.err); end
        vectors++; if (enp !== 4'h0) begin miscompares++; $display("FAIL stall_enable_after got %b exp 0000", enp); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 4'd0; pwdata = 8'h99; ch_ready = 4'b1110;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #2;
        vectors++; if (o_enable !== 4'b0001) begin miscompares++; $display("FAIL rmid_enable_before got %b exp 0001", o_enable); end
        #1;
        rst_n = 1'b0;
        #1;
        vectors++; if (o_enable !== 4'h0) begin miscompares++; $display("FAIL rmid_enable_async got %b exp 0000", o_enable); end
        vectors++; if (o_wdata !== 8'h00 || o_write !== 1'b0) begin
            miscompares++; $display("FAIL rmid_latched got wdata=%h write=%b exp wdata=00 write=0", o_wdata, o_write);
        end
        @(negedge clk);
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0; ch_ready = 4'hF;
        sb.push_back('{8'h77, 1'b0, 1, 4'b0100, 1'b1});
        do_xfer(1'b0, 4'd2, 8'h00, 0, 20, acc, en1, enst, rd, err, rdw, done, enp, wdo, wro);
        e = sb.pop_front();
        vectors++; if (done !== e.done || acc !== e.acc) begin
            miscompares++; $display("FAIL rmid_after_xfer got done=%b cycles=%0d exp done=%b cycles=%0d", done, acc, e.done, e.acc);
        end
        vectors++; if (en1 !== e.en) begin miscompares++; $display("FAIL rmid_after_enable got %b exp %b", en1, e.en); end
        vectors++; if (rd !== e.rd || err !== e.err) begin
            miscompares++; $display("FAIL rmid_after_resp got rd=%h err=%b exp rd=%h err=%b", rd, err, e.rd, e.err);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_invalid();
        test_setup_abort();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/apb_slave_decoder.md
APB_SLAVE_DECODER -- requirements
Module: apb_slave_decoder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, width of i_Paddr.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, APB and channel data width.
REQ-003 SHALL have parameter NUM_CH, default 4, number of downstream channels (1..2^ADDR_WIDTH).
REQ-004 SHALL have parameter TIMEOUT, default 15, max wait-state cycles before forced error (used only with APB_TIMEOUT_EN).
REQ-005 SHALL have port i_Pclk  in  1  the only clock; all logic is on its rising edge.
REQ-006 SHALL have port i_Presetn  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port i_Psel  in  1  APB select.
REQ-008 SHALL have port i_Penable  in  1  APB enable (access phase).
REQ-009 SHALL have port i_Pwrite  in  1  1 = write, 0 = read.
REQ-010 SHALL have port i_Paddr  in  ADDR_WIDTH  channel index.
REQ-011 SHALL have port i_Pwdata  in  DATA_WIDTH  write data.
REQ-012 SHALL have port o_Prdata  out  DATA_WIDTH  read data.
REQ-013 SHALL have port o_Pready  out  1  transfer-complete strobe.
REQ-014 SHALL have port o_Pslverr  out  1  transfer error, valid only with o_Pready.
REQ-015 SHALL have port o_Enable  out  NUM_CH  one-hot channel enable.
REQ-016 SHALL have port o_Write  out  1  latched direction to channels.
REQ-017 SHALL have port o_Wdata  out  DATA_WIDTH  latched write data to channels.
REQ-018 SHALL have port i_Ch_Ready  in  NUM_CH  per-channel ready; low inserts wait states.
REQ-019 SHALL have port i_Ch_Rdata  in  NUM_CH*DATA_WIDTH  per-channel read data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-020 SHALL implement FSM IDLE, SETUP, ACCESS, registered on i_Pclk.
REQ-021 IDLE: i_Psel=1 and i_Penable=0 -> SETUP, latching i_Paddr, i_Pwrite, i_Pwdata into internal registers.
REQ-022 SETUP: i_Psel=1 and i_Penable=1 -> ACCESS; any other input -> IDLE (protocol abort, no enable issued).
REQ-023 ACCESS, valid address (latched addr < NUM_CH): o_Enable[addr]=1, all other bits 0; o_Pready = i_Ch_Ready[addr] combinationally.
REQ-024 ACCESS, invalid address (>= NUM_CH): o_Enable all 0; o_Pready=1 and o_Pslverr=1 in the first ACCESS cycle.
REQ-025 Transfer completes on the edge where state=ACCESS and o_Pready=1; next state SETUP if i_Psel=1 and i_Penable=0 (back-to-back, re-latching inputs), else IDLE.
REQ-026 ACCESS with i_Psel=0 or i_Penable=0 before completion SHALL abort to IDLE with o_Enable cleared next cycle.
REQ-027 o_Prdata SHALL equal the selected channel slice when ACCESS, read, valid address and o_Pready=1; else all zeros.
REQ-028 o_Write and o_Wdata SHALL present latched values from SETUP onward, held until next latch.
REQ-029 o_Pready, o_Pslverr, o_Enable SHALL be 0 in IDLE and SETUP.
REQ-030 Minimum transfer: 2 cycles (SETUP + 1 ACCESS); each low cycle of selected i_Ch_Ready adds exactly one cycle.

Reset
REQ-031 i_Presetn=0 SHALL immediately force state IDLE, latched addr/write/wdata to 0, wait counter to 0, all outputs 0, independent of i_Pclk.
REQ-032 Reset asserted mid-ACCESS SHALL drop o_Enable without waiting for a clock; first transfer after release starts from IDLE.

Configuration
REQ-033 Macro APB_TIMEOUT_EN defined: a counter (width clog2(TIMEOUT+1)) clears on entering ACCESS, increments each ACCESS cycle with i_Ch_Ready[addr]=0; when it equals TIMEOUT, o_Pready=1 and o_Pslverr=1 that cycle, transfer completes per REQ-025.
REQ-034 Macro APB_TIMEOUT_EN undefined: no counter; wait states unbounded; o_Pslverr asserted only per REQ-024.

Verification
REQ-035 Write addr=2, wdata=0xA5, i_Ch_Ready=4'b1111 -> o_Enable=4'b0100 for exactly 1 cycle, o_Wdata=0xA5, o_Write=1, o_Pready=1, o_Pslverr=0.
REQ-036 Read addr=1, i_Ch_Rdata ch1=0x3C, ch1 ready low 5 cycles -> o_Enable=4'b0010 for 6 cycles, o_Pready on 6th, o_Prdata=0x3C only that cycle.
REQ-037 Read addr=7 (NUM_CH=4) -> o_Enable=0, o_Pready=1 and o_Pslverr=1 in first ACCESS cycle, o_Prdata=0.
REQ-038 Back-to-back write ch0 then read ch3, i_Psel held high -> SETUP follows completion directly, no IDLE cycle, enables 4'b0001 then 4'b1000.
REQ-039 With APB_TIMEOUT_EN, TIMEOUT=15, ch0 ready held low -> o_Pready=1, o_Pslverr=1 on 16th ACCESS cycle; without macro -> o_Pready stays 0 for 100 cycles.
REQ-040 i_Presetn pulsed low mid-ACCESS -> o_Enable=0 asynchronously; next valid transfer completes normally.
